// File: rtl/calc_pkg.sv
// Shared types and defaults for the calc controller: FSM encoding, field widths,
// and the default settle time and command FIFO depth.
package calc_pkg;

  localparam int OP_W       = 2;
  localparam int RES_W      = 8;
  localparam int CNT_W      = 8;
  localparam int SETTLE_DEF = 2;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } calc_state_e;

endpackage

// File: rtl/calc_if.sv
// Bus between the requester/consumer, the external calc datapath and calc_ctrl.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid, once raised, holds its payload stable until that edge.
interface calc_if;
  import calc_pkg::*;

  logic             cmd_valid;
  logic [OP_W-1:0]  cmd_op;
  logic             cmd_ready;
  logic             comA;
  logic             comB;
  logic [RES_W-1:0] outC;
  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic [OP_W-1:0]  res_op;
  logic             res_ready;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  modport slave (
    input  cmd_valid, cmd_op, outC, res_ready,
    output cmd_ready, comA, comB, res_valid, res_data, res_op, busy, done_cnt
  );

  modport master (
    output cmd_valid, cmd_op, outC, res_ready,
    input  cmd_ready, comA, comB, res_valid, res_data, res_op, busy, done_cnt
  );

endinterface

// File: rtl/calc_cmd_fifo.sv
// Power-of-two command FIFO with synchronous reset; push is refused when full
// even if a pop happens on the same edge.
module calc_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [W-1:0]            data_i,
  input  logic                    pop_i,
  output logic [W-1:0]            data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/calc_ctrl.sv
// Sequences queued opcodes onto the external calc datapath: drive comA/comB, wait
// SETTLE cycles, capture outC, and hold the result until the consumer takes it.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  calc_if.slave                  bus,
  output calc_state_e            state_o,
  output logic [$clog2(DEPTH):0] fifo_cnt_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  calc_state_e      state_q;
  logic [3:0]       settle_q;
  logic             com_a_q;
  logic             com_b_q;
  logic             res_valid_q;
  logic [RES_W-1:0] res_data_q;
  logic [OP_W-1:0]  res_op_q;
  logic [CNT_W-1:0] done_cnt_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [OP_W-1:0]  head_op;
  logic [CW-1:0]    fifo_cnt;

  assign push = bus.cmd_valid && !fifo_full;
  assign pop  = (state_q == ST_IDLE) && !fifo_empty;

  calc_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (OP_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (bus.cmd_op),
    .pop_i   (pop),
    .data_o  (head_op),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      com_a_q     <= 1'b0;
      com_b_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      done_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            {com_a_q, com_b_q} <= head_op;
            res_op_q           <= head_op;
            settle_q           <= 4'(SETTLE - 1);
            state_q            <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == 4'd0) state_q <= ST_CAPTURE;
          else                  settle_q <= settle_q - 4'd1;
        end
        ST_CAPTURE: begin
          res_data_q  <= bus.outC;
          res_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          // comA/comB stay driven until the consumer takes the result.
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            com_a_q     <= 1'b0;
            com_b_q     <= 1'b0;
            done_cnt_q  <= done_cnt_q + 8'd1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.comA      = com_a_q;
  assign bus.comB      = com_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_op    = res_op_q;
  assign bus.busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.done_cnt  = done_cnt_q;
  assign state_o       = state_q;
  assign fifo_cnt_o    = fifo_cnt;

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: transaction-timeline model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_calc_ctrl;
  import calc_pkg::*;

  localparam int SETTLE = 2;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  calc_state_e dut_state;
  logic [2:0]  dut_cnt;

  always #5 clk = ~clk;

  calc_if bus ();

  assign bus.outC = {4'hA, 2'b00, bus.comA, bus.comB};

  calc_ctrl #(.SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .state_o    (dut_state),
    .fifo_cnt_o (dut_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Queue of waiting ops, one op in flight aged in edges since its pop; the result
  // is presented SETTLE+1 edges after the pop and held until taken.
  logic [1:0] m_q[$];
  logic [7:0] exp_q[$];
  bit         m_ok = 0;
  bit         m_act = 0;
  int         m_t = 0;
  logic [1:0] m_op = '0;
  logic [1:0] m_rop = '0;
  logic [7:0] m_data = '0;
  logic [7:0] m_done = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_ok   = 1;
      m_act  = 0;
      m_t    = 0;
      m_op   = '0;
      m_rop  = '0;
      m_data = '0;
      m_done = '0;
    end else if (m_ok) begin
      bit push_ok;
      push_ok = bus.cmd_valid && (m_q.size() < DEPTH);
      if (m_act) begin
        if (m_t == SETTLE + 1) begin
          if (bus.res_ready) begin
            m_act  = 0;
            m_done = m_done + 8'd1;
          end
        end else begin
          m_t++;
          if (m_t == SETTLE + 1) m_data = {4'hA, 2'b00, m_op};
        end
      end else if (m_q.size() > 0) begin
        m_op  = m_q.pop_front();
        m_rop = m_op;
        m_act = 1;
        m_t   = 0;
      end
      if (push_ok) begin
        m_q.push_back(bus.cmd_op);
        exp_q.push_back({4'hA, 2'b00, bus.cmd_op});
      end
    end
  end

  // ---------------- compare process + scoreboard ----------------
  logic [7:0] got_q[$];
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = '0;

  always @(posedge clk) begin
    if (!rst && prev_v && bus.res_ready) begin
      got_q.push_back(prev_d);
      if (exp_q.size() == 0) chk("sb_unexpected_result", prev_d, 32'hFFFF);
      else chk("sb_result", prev_d, exp_q.pop_front());
    end
    #1;
    if (m_ok) begin
      chk("cmd_ready", bus.cmd_ready, (m_q.size() < DEPTH));
      chk("comA", bus.comA, m_act ? m_op[1] : 1'b0);
      chk("comB", bus.comB, m_act ? m_op[0] : 1'b0);
      chk("res_valid", bus.res_valid, (m_act && m_t == SETTLE + 1));
      chk("res_data", bus.res_data, m_data);
      chk("res_op", bus.res_op, m_rop);
      chk("busy", bus.busy, (m_act || m_q.size() > 0));
      chk("done_cnt", bus.done_cnt, m_done);
    end
    prev_v = rst ? 1'b0 : bus.res_valid;
    prev_d = bus.res_data;
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [1:0] op);
    bit ok = 0;
    bus.cmd_op    = op;
    bus.cmd_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (bus.cmd_ready) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!bus.busy) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_res_valid();
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (bus.res_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("res_valid_timeout", 0, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int lat;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.res_ready = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 8'h00);
    chk("rst_res_op", bus.res_op, 2'b00);
    chk("rst_done_cnt", bus.done_cnt, 8'h00);
    chk("rst_com", {bus.comA, bus.comB}, 2'b00);
    chk("rst_busy", bus.busy, 0);

    // Single op 11: result 4 edges after acceptance.
    bus.res_ready = 1'b1;
    bus.cmd_op    = 2'b11;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        lat = n;
        break;
      end
    end
    chk("latency", lat, 4);
    chk("single_res_data", bus.res_data, 8'hA3);
    chk("single_res_op", bus.res_op, 2'b11);
    @(negedge clk);
    chk("single_done_cnt", bus.done_cnt, 8'd1);
    chk("single_res_valid_drop", bus.res_valid, 0);
    wait_idle();

    // Hold an op 10 in HOLD, then queue 00,01,10,11 and keep 01 pending.
    bus.res_ready = 1'b0;
    got_q.delete();
    push_cmd(2'b10);
    bus.cmd_valid = 1'b0;
    wait_res_valid();
    push_cmd(2'b00);
    push_cmd(2'b01);
    push_cmd(2'b10);
    push_cmd(2'b11);
    chk("ready_low_after_4", bus.cmd_ready, 0);
    chk("fifo_cnt_4", dut_cnt, 3'd4);
    bus.cmd_op = 2'b01;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("hold_res_data", bus.res_data, 8'hA2);
      chk("hold_res_op", bus.res_op, 2'b10);
      chk("hold_com", {bus.comA, bus.comB}, 2'b10);
      chk("hold_busy", bus.busy, 1);
    end
    bus.res_ready = 1'b1;
    push_cmd(2'b01);
    bus.cmd_valid = 1'b0;
    wait_idle();
    chk("order_count", got_q.size(), 6);
    if (got_q.size() == 6) begin
      chk("order_0", got_q[0], 8'hA2);
      chk("order_1", got_q[1], 8'hA0);
      chk("order_2", got_q[2], 8'hA1);
      chk("order_3", got_q[3], 8'hA2);
      chk("order_4", got_q[4], 8'hA3);
      chk("order_5", got_q[5], 8'hA1);
    end
    chk("done_after_order", bus.done_cnt, 8'd7);

    // Reset during SETTLE with two commands queued.
    push_cmd(2'b11);
    push_cmd(2'b01);
    push_cmd(2'b10);
    bus.cmd_valid = 1'b0;
    chk("pre_rst_state", dut_state, ST_SETTLE);
    chk("pre_rst_cnt", dut_cnt, 3'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      chk("post_rst_no_valid", bus.res_valid, 0);
      @(negedge clk);
    end
    chk("post_rst_com", {bus.comA, bus.comB}, 2'b00);
    chk("post_rst_ready", bus.cmd_ready, 1);
    chk("post_rst_done", bus.done_cnt, 8'h00);
    chk("post_rst_busy", bus.busy, 0);

    // 256 results wrap done_cnt to 0, the next gives 1.
    for (int i = 0; i < 256; i++) begin
      logic [1:0] op;
      op = 2'(i);
      push_cmd(op);
    end
    bus.cmd_valid = 1'b0;
    wait_idle();
    chk("wrap_256", bus.done_cnt, 8'h00);
    push_cmd(2'b10);
    bus.cmd_valid = 1'b0;
    wait_idle();
    chk("wrap_257", bus.done_cnt, 8'h01);

    // Push on the pop edge with a full FIFO is refused.
    bus.res_ready = 1'b0;
    push_cmd(2'b01);
    bus.cmd_valid = 1'b0;
    wait_res_valid();
    push_cmd(2'b00);
    push_cmd(2'b11);
    push_cmd(2'b10);
    push_cmd(2'b01);
    bus.cmd_valid = 1'b0;
    chk("full_cnt", dut_cnt, 3'd4);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("collide_state_idle", dut_state, ST_IDLE);
    bus.cmd_op    = 2'b10;
    bus.cmd_valid = 1'b1;
    chk("collide_ready_low", bus.cmd_ready, 0);
    @(negedge clk);
    chk("collide_cnt_3", dut_cnt, 3'd3);
    chk("collide_ready_high", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b0;
    wait_idle();
    chk("final_done", bus.done_cnt, 8'h06);
    chk("sb_drained", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
